matrix_key_scanner: RTL and testbench

- 4x4 matrix keypad scanner with debounce.
- Drives keypad rows active-low one at a time and samples the active-low column inputs, which have pull-ups.
- Produces a stable 4-bit key code, a held flag and a one-cycle new-key strobe.
- Sits directly upstream of the matrix-key 7-segment decoder: key_code feeds its idat input, pushed feeds its pushed input.

---
 rtl/matrix_key_scanner.sv | 161 ++++++++++++++++
 tb/tb_matrix_key_scanner.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/matrix_key_scanner.sv
// matrix_key_scanner: 4x4 keypad row scanner with frame-based debounce.
// Ports: clk, rst_n (async, active-low), col_n[3:0] (active-low columns),
//        row_n[3:0] (one row driven low), key_code[3:0] (4*row+col),
//        pushed (debounced key held), key_valid (one-cycle press strobe).
// Optional: define KEY_REPEAT_EN for key_valid auto-repeat every REPEAT_FRAMES.
module matrix_key_scanner #(
  parameter int SCAN_DIV = 12500,
  parameter int DEB_FRAMES = 10,
  parameter int REPEAT_FRAMES = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       pushed,
  output logic       key_valid
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEB_FRAMES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_FRAMES);
  typedef enum logic [1:0] {IDLE, CAND, HELD, REL} state_t;
  if (SCAN_DIV < 4 || DEB_FRAMES < 1 || REPEAT_FRAMES < 1) begin : g_bad_param
    $error("matrix_key_scanner: illegal parameter value");
  end
  logic [3:0] col_m_q, col_s_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0] row_q, row_d, row_col;
  logic acc_found_q, acc_found_d, hit_found, tick, last_row;
  logic [3:0] acc_code_q, acc_code_d, hit_code;
  logic frame_done_q, frame_done_d, fr_none_q, fr_none_d;
  logic [3:0] fr_code_q, fr_code_d;
  state_t state_q, state_d;
  logic [3:0] cand_q, cand_d, key_code_q, key_code_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic pushed_q, pushed_d, key_valid_q, key_valid_d, accept, drop;
`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_FRAMES - 1);
  logic [RW-1:0] rep_q, rep_d;
`endif
  assign row_n = ~(4'b0001 << row_q);
  assign key_code = key_code_q;
  assign pushed = pushed_q;
  assign key_valid = key_valid_q;
  // Rows are visited in ascending order, so the first hit of a frame is its lowest code.
  always_comb begin
    tick = dwell_q == DWELL_LAST;
    dwell_d = tick ? '0 : dwell_q + 1'b1;
    row_d = tick ? row_q + 2'd1 : row_q;
    row_col = ~col_s_q[0] ? 2'd0 : ~col_s_q[1] ? 2'd1 : ~col_s_q[2] ? 2'd2 : 2'd3;
    hit_found = acc_found_q | ~&col_s_q;
    hit_code = acc_found_q ? acc_code_q : {row_q, row_col};
    last_row = tick && row_q == 2'd3;
    acc_found_d = last_row ? 1'b0 : tick ? hit_found : acc_found_q;
    acc_code_d = last_row ? 4'd0 : tick ? hit_code : acc_code_q;
    frame_done_d = last_row;
    fr_none_d = last_row ? ~hit_found : fr_none_q;
    fr_code_d = last_row ? hit_code : fr_code_q;
  end
  always_comb begin
    state_d = state_q;
    cand_d = cand_q;
    cnt_d = cnt_q;
    key_code_d = key_code_q;
    pushed_d = pushed_q;
    key_valid_d = 1'b0;
    accept = 1'b0;
    drop = 1'b0;
    cnt_inc = cnt_q == DEB_LAST ? cnt_q : cnt_q + CNT_ONE;
`ifdef KEY_REPEAT_EN
    rep_d = state_q == HELD ? rep_q : '0;
`endif
    if (frame_done_q) begin
      case (state_q)
        IDLE: if (!fr_none_q) begin
          state_d = CAND;
          cand_d = fr_code_q;
          cnt_d = CNT_ONE;
          accept = DEB_FRAMES == 1;
        end
        CAND: if (fr_none_q) state_d = IDLE;
          else if (fr_code_q != cand_q) begin
            cand_d = fr_code_q;
            cnt_d = CNT_ONE;
          end else begin
            cnt_d = cnt_inc;
            accept = cnt_inc == DEB_LAST;
          end
        HELD: if (fr_none_q || fr_code_q != key_code_q) begin
          state_d = REL;
          cnt_d = CNT_ONE;
          drop = DEB_FRAMES == 1;
        end else begin
`ifdef KEY_REPEAT_EN
          key_valid_d = rep_q == REP_LAST;
          rep_d = rep_q == REP_LAST ? '0 : rep_q + 1'b1;
`endif
        end
        REL: if (!fr_none_q && fr_code_q == key_code_q) state_d = HELD;
          else begin
            cnt_d = cnt_inc;
            drop = cnt_inc == DEB_LAST;
          end
      endcase
      if (accept) begin
        state_d = HELD;
        key_code_d = fr_code_q;
        pushed_d = 1'b1;
        key_valid_d = 1'b1;
      end
      if (drop) begin
        state_d = IDLE;
        pushed_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_m_q <= 4'hf;
      col_s_q <= 4'hf;
      dwell_q <= '0;
      row_q <= 2'd0;
      acc_found_q <= 1'b0;
      acc_code_q <= 4'd0;
      frame_done_q <= 1'b0;
      fr_none_q <= 1'b1;
      fr_code_q <= 4'd0;
      state_q <= IDLE;
      cand_q <= 4'd0;
      cnt_q <= '0;
      key_code_q <= 4'd0;
      pushed_q <= 1'b0;
      key_valid_q <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_q <= '0;
`endif
    end else begin
      col_m_q <= col_n;
      col_s_q <= col_m_q;
      dwell_q <= dwell_d;
      row_q <= row_d;
      acc_found_q <= acc_found_d;
      acc_code_q <= acc_code_d;
      frame_done_q <= frame_done_d;
      fr_none_q <= fr_none_d;
      fr_code_q <= fr_code_d;
      state_q <= state_d;
      cand_q <= cand_d;
      cnt_q <= cnt_d;
      key_code_q <= key_code_d;
      pushed_q <= pushed_d;
      key_valid_q <= key_valid_d;
`ifdef KEY_REPEAT_EN
      rep_q <= rep_d;
`endif
    end
  end
endmodule

// File: tb/tb_matrix_key_scanner.sv
// tb_matrix_key_scanner: directed vector table, corner sequences and randomized frames vs a reference model.
module tb_matrix_key_scanner;
  localparam int DEB = 3;
  localparam int REP = 5;
`ifdef KEY_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif
  typedef struct {
    logic [15:0] m;
    int c;
    int p;
    int k;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] col_n, row_n, key_code;
  logic pushed, key_valid;
  logic [15:0] mask = 16'h0;
  int checks = 0, errors = 0, edges = 0, kv_seen = 0, kv_exp = 0;
  int m_held, m_code, m_last, m_streak, m_rel, m_rep, m_kv;
  vec_t tbl[$];
  matrix_key_scanner #(.SCAN_DIV(4), .DEB_FRAMES(DEB), .REPEAT_FRAMES(REP)) dut (
    .clk(clk), .rst_n(rst_n), .col_n(col_n), .row_n(row_n),
    .key_code(key_code), .pushed(pushed), .key_valid(key_valid)
  );
  always #5 clk = ~clk;
  always_comb begin
    col_n = 4'hf;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && mask[4*r+c]) col_n[c] = 1'b0;
  end
  always @(negedge clk) if (rst_n && key_valid) kv_seen++;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  function automatic int lowest(input logic [15:0] m);
    for (int k = 0; k < 16; k++) if (m[k]) return k;
    return 16;
  endfunction
  task automatic model_reset();
    m_held = 0; m_code = 0; m_last = 0; m_streak = 0; m_rel = 0; m_rep = 0; m_kv = 0;
  endtask
  task automatic model_step(input int r);
    m_kv = 0;
    if (m_held == 0) begin
      if (r == 16) m_streak = 0;
      else begin
        m_streak = (m_streak > 0 && r == m_last) ? m_streak + 1 : 1;
        m_last = r;
      end
      if (m_streak >= DEB) begin
        m_held = 1; m_code = r; m_kv = 1; m_rep = 0; m_rel = 0;
      end
    end else if (r == m_code) begin
      if (m_rel > 0) begin
        m_rel = 0; m_rep = 0;
      end else begin
        m_rep++;
        if (REPEAT_ON && m_rep == REP) begin
          m_kv = 1; m_rep = 0;
        end
      end
    end else begin
      m_rel++;
      m_rep = 0;
      if (m_rel >= DEB) begin
        m_held = 0; m_streak = 0;
      end
    end
  endtask
  task automatic tick();
    logic [3:0] exp_row;
    @(posedge clk);
    #1;
    edges++;
    exp_row = ~(4'b0001 << ((edges / 4) % 4));
    chk("row_n", int'(row_n), int'(exp_row));
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    edges = 0;
    model_reset();
    tick();
  endtask
  // Inputs change one cycle into row 0; outputs for the frame are checked one cycle after its row-3 sample.
  task automatic frame(input logic [15:0] m, input bit use_model, input int ec, input int ep, input int ek);
    int c, p, k;
    mask = m;
    model_step(lowest(m));
    c = use_model ? m_code : ec;
    p = use_model ? m_held : ep;
    k = use_model ? m_kv : ek;
    repeat (16) tick();
    chk("key_code", int'(key_code), c);
    chk("pushed", int'(pushed), p);
    chk("key_valid", int'(key_valid), k);
    kv_exp += k;
  endtask
  task automatic add(input logic [15:0] m, input int c, input int p, input int k, input int n);
    vec_t v;
    v.m = m; v.c = c; v.p = p; v.k = k;
    repeat (n) tbl.push_back(v);
  endtask
  initial begin
    logic [15:0] m, k3_12;
    int kv0;
    k3_12 = 16'h1008;
    add(16'h0000, 0, 0, 0, 10);
    add(16'h0200, 0, 0, 0, 2); add(16'h0200, 9, 1, 1, 1); add(16'h0200, 9, 1, 0, 3);
    add(16'h0000, 9, 1, 0, 2); add(16'h0200, 9, 1, 0, 1);
    add(16'h0000, 9, 1, 0, 2); add(16'h0000, 9, 0, 0, 1);
    add(16'h0020, 9, 0, 0, 2); add(16'h0000, 9, 0, 0, 1);
    add(16'h0020, 9, 0, 0, 2); add(16'h0020, 5, 1, 1, 1);
    add(16'h0000, 5, 1, 0, 2); add(16'h0000, 5, 0, 0, 1);
    add(k3_12, 5, 0, 0, 2); add(k3_12, 3, 1, 1, 1); add(16'h9008, 3, 1, 0, 2);
    #2;
    chk("rst row_n", int'(row_n), 14);
    chk("rst key_code", int'(key_code), 0);
    chk("rst pushed", int'(pushed), 0);
    chk("rst key_valid", int'(key_valid), 0);
    do_reset();
    foreach (tbl[i]) frame(tbl[i].m, 1'b0, tbl[i].c, tbl[i].p, tbl[i].k);
    mask = k3_12;
    repeat (6) tick();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async row_n", int'(row_n), 14);
    chk("async key_code", int'(key_code), 0);
    chk("async pushed", int'(pushed), 0);
    chk("async key_valid", int'(key_valid), 0);
    do_reset();
    frame(k3_12, 1'b0, 0, 0, 0);
    frame(k3_12, 1'b0, 0, 0, 0);
    frame(k3_12, 1'b0, 3, 1, 1);
    frame(16'h0000, 1'b0, 3, 1, 0);
    frame(16'h0000, 1'b0, 3, 1, 0);
    frame(16'h0000, 1'b0, 3, 0, 0);
    m = 16'h0;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) >= 7) begin
        case ($urandom_range(0, 3))
          0: m = 16'h0;
          1, 2: m = 16'(1) << $urandom_range(0, 15);
          default: m = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
        endcase
      end
      frame(m, 1'b1, 0, 0, 0);
    end
    do_reset();
    kv0 = kv_seen;
    for (int i = 0; i < 16; i++) frame(16'h0001, 1'b1, 0, 0, 0);
    chk("hold16 pulses", kv_seen - kv0, REPEAT_ON ? 3 : 1);
    chk("total key_valid pulses", kv_seen, kv_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
